// File: rtl/face_detect_haar_accum_pkg.sv
// Shared types, default widths and sign-extension helper for the Haar feature accumulator.
// The FACE_DETECT_HAAR_ACCUM_SAT_EN macro (see the addsat sub-module) selects saturating adds.
package face_detect_pkg;

   localparam int unsigned DATA_W = 24;
   localparam int unsigned ACC_W  = 32;
   localparam int unsigned VOTE_W = 16;
   localparam int unsigned SEXT_W = 64;

   typedef enum logic [0:0] {S_ACC, S_OUT} state_e;

   // Replicate bit w-1 of v into every higher bit; callers truncate to ACC_W.
   function automatic logic [SEXT_W-1:0] sext(input logic [SEXT_W-1:0] v, input int unsigned w);
      logic [SEXT_W-1:0] r;
      r = v;
      for (int unsigned i = 0; i < SEXT_W; i++) begin
         if (i >= w) r[i] = v[w-1];
      end
      return r;
   endfunction

endpackage

// File: rtl/face_detect_haar_accum_if.sv
// Valid/ready product input and result output bundle of the Haar feature accumulator.
interface face_detect_haar_accum_if #(
   parameter int unsigned DATA_W = 24,
   parameter int unsigned ACC_W  = 32,
   parameter int unsigned VOTE_W = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_prod;
   logic              in_last;
   logic [DATA_W-1:0] in_thresh;
   logic [VOTE_W-1:0] in_left;
   logic [VOTE_W-1:0] in_right;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_sum;
   logic              out_pass;
   logic [VOTE_W-1:0] out_vote;
   logic              out_err;

   modport master (
      output in_valid, in_prod, in_last, in_thresh, in_left, in_right, out_ready,
      input  in_ready, out_valid, out_sum, out_pass, out_vote, out_err
   );

   modport slave (
      input  in_valid, in_prod, in_last, in_thresh, in_left, in_right, out_ready,
      output in_ready, out_valid, out_sum, out_pass, out_vote, out_err
   );
endinterface

// File: rtl/face_detect_haar_addsat.sv
// Combinational accumulator adder; FACE_DETECT_HAAR_ACCUM_SAT_EN clamps signed overflow.
module face_detect_haar_addsat #(
   parameter int unsigned ACC_W = 32
) (
   input  logic [ACC_W-1:0] a,
   input  logic [ACC_W-1:0] b,
   output logic [ACC_W-1:0] sum
);
   logic [ACC_W-1:0] raw;

   assign raw = a + b;

`ifdef FACE_DETECT_HAAR_ACCUM_SAT_EN
   logic ovf;

   // Overflow only when both operands share a sign the result does not.
   assign ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);

   always_comb begin
      sum = raw;
      if (ovf) sum = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
   end
`else
   assign sum = raw;
`endif
endmodule

// File: rtl/face_detect_haar_accum.sv
// Accumulates one Haar feature's weighted rectangle products and emits the thresholded vote.
// Build with FACE_DETECT_HAAR_ACCUM_SAT_EN for saturating accumulation.
module face_detect_haar_accum #(
   parameter int unsigned DATA_W       = face_detect_pkg::DATA_W,
   parameter int unsigned ACC_W        = face_detect_pkg::ACC_W,
   parameter int unsigned VOTE_W       = face_detect_pkg::VOTE_W,
   parameter int unsigned NUM_RECT_MAX = 3
) (
   input logic                   clk,
   input logic                   reset,
   face_detect_haar_accum_if.slave bus
);
   import face_detect_pkg::*;

   localparam int unsigned CNT_W = $clog2(NUM_RECT_MAX + 1);

   state_e           state, state_next;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] prod_ext;
   logic [ACC_W-1:0] thresh_ext;
   logic [ACC_W-1:0] final_sum;
   logic [CNT_W-1:0] beat_cnt;
   logic             fire;
   logic             force_last;
   logic             is_last;
   logic             pass;

   assign prod_ext   = ACC_W'(sext(SEXT_W'(bus.in_prod), DATA_W));
   assign thresh_ext = ACC_W'(sext(SEXT_W'(bus.in_thresh), DATA_W));

   face_detect_haar_addsat #(
      .ACC_W (ACC_W)
   ) u_addsat (
      .a   (acc),
      .b   (prod_ext),
      .sum (final_sum)
   );

   assign bus.in_ready = (state == S_ACC) || bus.out_ready;
   assign fire         = bus.in_valid && bus.in_ready;
   // A beat past NUM_RECT_MAX closes the feature even without in_last.
   assign force_last   = (beat_cnt == CNT_W'(NUM_RECT_MAX)) && !bus.in_last;
   assign is_last      = bus.in_last || force_last;
   assign pass         = $signed(final_sum) >= $signed(thresh_ext);

   always_ff @(posedge clk) begin
      if (reset) state <= S_ACC;
      else       state <= state_next;
   end

   always_comb begin
      state_next    = state;
      bus.out_valid = 1'b0;
      unique case (state)
         S_ACC: begin
            if (fire && is_last) state_next = S_OUT;
         end
         S_OUT: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_next = (fire && is_last) ? S_OUT : S_ACC;
         end
         default: state_next = S_ACC;
      endcase
   end

   // acc is zero whenever a result is held, so the S_OUT overlap path shares this datapath.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc          <= '0;
         beat_cnt     <= '0;
         bus.out_sum  <= '0;
         bus.out_pass <= 1'b0;
         bus.out_vote <= '0;
         bus.out_err  <= 1'b0;
      end else if (fire) begin
         if (is_last) begin
            acc          <= '0;
            beat_cnt     <= '0;
            bus.out_sum  <= final_sum;
            bus.out_pass <= pass;
            bus.out_vote <= pass ? bus.in_right : bus.in_left;
            bus.out_err  <= bus.out_err | force_last;
         end else begin
            acc      <= final_sum;
            beat_cnt <= beat_cnt + CNT_W'(1);
         end
      end
   end
endmodule
